// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the byte FIFO and its UART drain.
//   fifo_ready : FIFO holds at least one byte
//   fifo_data  : FIFO head byte, valid whenever fifo_ready is high
//   fifo_read  : one-cycle pop strobe back to the FIFO
// master = FIFO side, slave = consumer (fifo_uart_tx).
interface fifo_uart_tx_if;
    logic       fifo_ready;
    logic [7:0] fifo_data;
    logic       fifo_read;

    modport master (output fifo_ready, output fifo_data, input fifo_read);
    modport slave  (input fifo_ready, input fifo_data, output fifo_read);
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO read port and serialises each one as an 8N1
// UART frame (start bit, 8 data bits LSB first, stop bit) on tx.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : allows a new frame to start (looked at only in IDLE)
//   fifo       : FIFO read port (slave side)
//   tx         : registered serial line, idle high
//   busy       : frame in progress (state != IDLE)
//   frame_done : one-cycle pulse on the first IDLE cycle after a stop bit
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    fifo_uart_tx_if.slave fifo,
    output logic          tx,
    output logic          busy,
    output logic          frame_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t           state, state_nx;
    logic [7:0]       shift, shift_nx;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_nx;
    logic [2:0]       bit_idx, bit_idx_nx;
    logic             tx_nx, done_nx;
    logic             cnt_last;

    assign cnt_last       = (clk_cnt == CNT_LAST);
    assign fifo.fifo_read = (state == LOAD);
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift      <= 8'h00;
            clk_cnt    <= '0;
            bit_idx    <= 3'd0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            shift      <= shift_nx;
            clk_cnt    <= clk_cnt_nx;
            bit_idx    <= bit_idx_nx;
            tx         <= tx_nx;
            frame_done <= done_nx;
        end
    end

    // tx is registered, so each branch computes the line level of the
    // state being entered; that keeps tx aligned with the state change.
    always_comb begin
        state_nx   = state;
        shift_nx   = shift;
        clk_cnt_nx = clk_cnt;
        bit_idx_nx = bit_idx;
        tx_nx      = tx;
        done_nx    = 1'b0;
        case (state)
            IDLE: begin
                tx_nx      = 1'b1;
                clk_cnt_nx = '0;
                if (enable && fifo.fifo_ready) state_nx = LOAD;
            end
            LOAD: begin
                // FIFO pops on this same edge; the byte is latched here.
                shift_nx   = fifo.fifo_data;
                clk_cnt_nx = '0;
                tx_nx      = 1'b0;
                state_nx   = START;
            end
            START: begin
                tx_nx = 1'b0;
                if (cnt_last) begin
                    clk_cnt_nx = '0;
                    bit_idx_nx = 3'd0;
                    tx_nx      = shift[0];
                    state_nx   = DATA;
                end else begin
                    clk_cnt_nx = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    clk_cnt_nx = '0;
                    shift_nx   = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        tx_nx    = 1'b1;
                        state_nx = STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                        tx_nx      = shift[1];   // next bit after the shift
                    end
                end else begin
                    clk_cnt_nx = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                tx_nx = 1'b1;
                if (cnt_last) begin
                    clk_cnt_nx = '0;
                    done_nx    = 1'b1;
                    state_nx   = IDLE;
                end else begin
                    clk_cnt_nx = clk_cnt + 1'b1;
                end
            end
            default: begin
                tx_nx    = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with N=4. A queue stands in for the 8-deep FIFO;
// each expected frame is drawn as a 10-slot line picture from the byte.
module tb_fifo_uart_tx;
    localparam int N = 4;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic enable = 1'b0;
    logic tx, busy, frame_done;

    fifo_uart_tx_if fif ();

    fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo       (fif.slave),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // FIFO model: pops the negedge after the strobe is seen (the DUT has
    // already latched the head on the posedge in between).
    logic [7:0] q[$];
    int         pops = 0;
    bit         pend = 1'b0;

    always @(negedge clk) begin
        if (pend) begin
            if (q.size() != 0) void'(q.pop_front());
            pend = 1'b0;
        end
        if (fif.fifo_read === 1'b1) begin
            pend = 1'b1;
            pops++;
        end
        fif.fifo_ready = (q.size() != 0);
        fif.fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level for frame slot 0..9: start, d0..d7, stop.
    function automatic logic line_bit(input logic [7:0] b, input int slot);
        logic [7:0] s;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        s = b >> (slot - 1);
        return s[0];
    endfunction

    // Waits (bounded) for the pop strobe, then checks the whole frame and
    // the frame_done cycle. wait_cyc = negedges waited before the strobe.
    task automatic run_frame(input logic [7:0] b, input bit drop_en, output int wait_cyc);
        int k = 0;
        while (fif.fifo_read !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        wait_cyc = k;
        chk("load_strobe", fif.fifo_read, 1);
        chk("load_tx", tx, 1);
        chk("load_busy", busy, 1);
        if (drop_en) enable = 1'b0;
        for (int c = 0; c < 10 * N; c++) begin
            @(negedge clk);
            chk($sformatf("tx_%02h_slot%0d", b, c / N), tx, line_bit(b, c / N));
            chk("frame_busy", busy, 1);
            chk("frame_no_pop", fif.fifo_read, 0);
            chk("frame_done_early", frame_done, 0);
        end
        @(negedge clk);
        chk("done_pulse", frame_done, 1);
        chk("done_busy", busy, 0);
        chk("done_tx", tx, 1);
    endtask

    logic [7:0] sent[$];
    logic [7:0] r;
    int         w;
    int         pops0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_read", fif.fifo_read, 0);
        chk("rst_done", frame_done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte
        q.push_back(8'hA5);
        enable = 1'b1;
        run_frame(8'hA5, 1'b0, w);
        chk("single_pops", pops, 1);

        // Back-to-back: line high for stop + IDLE + LOAD between frames
        q.push_back(8'h00);
        q.push_back(8'hFF);
        run_frame(8'h00, 1'b0, w);
        run_frame(8'hFF, 1'b0, w);
        chk("b2b_gap", N + 1 + w, N + 2);
        chk("b2b_pops", pops, 3);
        @(negedge clk);
        chk("b2b_empty", fif.fifo_ready, 0);

        // Empty FIFO with enable high
        repeat (100) begin
            @(negedge clk);
            chk("empty_read", fif.fifo_read, 0);
            chk("empty_tx", tx, 1);
            chk("empty_busy", busy, 0);
        end

        // Enable gating, then drop enable mid-frame
        enable = 1'b0;
        q.push_back(8'h3C);
        repeat (50) begin
            @(negedge clk);
            chk("gate_read", fif.fifo_read, 0);
            chk("gate_busy", busy, 0);
        end
        enable = 1'b1;
        run_frame(8'h3C, 1'b1, w);
        chk("gate_latency", w, 1);
        r = 8'($urandom);
        sent.push_back(r);
        q.push_back(r);
        pops0 = pops;
        repeat (30) begin
            @(negedge clk);
            chk("gate_hold_read", fif.fifo_read, 0);
        end
        chk("gate_hold_pops", pops, pops0);

        // Random bytes, scoreboarded in order
        repeat (3) begin
            r = 8'($urandom_range(0, 255));
            sent.push_back(r);
            q.push_back(r);
        end
        enable = 1'b1;
        while (sent.size() != 0) run_frame(sent.pop_front(), 1'b0, w);
        chk("rand_pops", pops, pops0 + 4);

        // Reset during data bit 3 of 0x5A
        @(negedge clk);
        q.push_back(8'h5A);
        w = 0;
        while (fif.fifo_read !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("rst_mid_load", fif.fifo_read, 1);
        repeat (18) @(negedge clk);
        chk("rst_mid_bit3", tx, line_bit(8'h5A, 4));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_read", fif.fifo_read, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pops0 = pops;
        repeat (60) begin
            @(negedge clk);
            chk("post_rst_done", frame_done, 0);
            chk("post_rst_read", fif.fifo_read, 0);
            chk("post_rst_tx", tx, 1);
        end
        chk("post_rst_pops", pops, pops0);

        // Full drain of 7 bytes
        for (int i = 1; i <= 7; i++) q.push_back(8'(i));
        for (int i = 1; i <= 7; i++) run_frame(8'(i), 1'b0, w);
        chk("drain_pops", pops, pops0 + 7);
        repeat (3) @(negedge clk);
        chk("drain_empty", fif.fifo_ready, 0);
        chk("drain_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
